mem_arbiter: RTL

Single-port memory arbiter and access sequencer for the processor core. It shares one memory2c-style memory between the instruction-fetch requester (PC/fetch) and the data requester (load/store path). It sequences each access through a fixed grant/access/response cycle and returns registered read data. It tells the PC when to stall, and on a halt it quiesces the memory, optionally raising the memory dump.

---
 rtl/mem_arbiter.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, combinational-read memory between the
// instruction-fetch requester and the load/store requester.
// Each access runs a fixed ACC (memory cycle) -> RSP (ready pulse) sequence.
// Read data is captured into registers at the end of the ACC cycle.
// Optional feature macro ARB_DUMP_ON_HALT_EN: when defined, the first HALTED
// cycle pulses mem_createdump with the memory enabled.
// When undefined, mem_createdump is tied low and HALTED never enables the memory.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_data,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              halt,
  output logic              pc_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_enable,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_createdump,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IF_ACC = 3'd1,
    D_ACC  = 3'd2,
    IF_RSP = 3'd3,
    D_RSP  = 3'd4,
    HALTED = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              last_data_q;      // 1: data requester was served last
  logic [DATA_W-1:0] if_data_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              err_q;

  // Previous-cycle copies of requester inputs for the stability checks
  logic              if_req_prev_q;
  logic              if_rdy_prev_q;
  logic [ADDR_W-1:0] if_addr_prev_q;
  logic              d_req_prev_q;
  logic              d_wr_prev_q;
  logic              d_rdy_prev_q;
  logic [ADDR_W-1:0] d_addr_prev_q;
  logic [DATA_W-1:0] d_wdata_prev_q;

  logic d_req_s;
  logic d_write_s;
  logic err_set_s;

  // A simultaneous read+write is flagged as an error and performed as a read
  assign d_req_s   = d_rd | d_wr;
  assign d_write_s = d_wr & ~d_rd;

  assign err_set_s = (d_rd & d_wr)
                   | (if_req & if_req_prev_q & ~if_rdy_prev_q & (if_addr != if_addr_prev_q))
                   | (d_req_s & d_req_prev_q & ~d_rdy_prev_q & (d_addr != d_addr_prev_q))
                   | (d_wr & d_wr_prev_q & ~d_rdy_prev_q & (d_wdata != d_wdata_prev_q));

  assign if_ready = (state_q == IF_RSP);
  assign d_ready  = (state_q == D_RSP);
  assign pc_stall = if_req & ~if_ready;
  assign if_data  = if_data_q;
  assign d_rdata  = d_rdata_q;
  assign err      = err_q;

`ifdef ARB_DUMP_ON_HALT_EN
  logic dump_done_q;

  // Remember that the dump pulse has been issued so it lasts exactly one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      dump_done_q <= 1'b0;
    end else if (state_q == HALTED) begin
      dump_done_q <= 1'b1;
    end else begin
      dump_done_q <= dump_done_q;
    end
  end
`endif

  // Next-state arbitration: halt has priority, then round-robin between requesters
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = HALTED;
        end else if (if_req && d_req_s) begin
          state_d = last_data_q ? IF_ACC : D_ACC;
        end else if (if_req) begin
          state_d = IF_ACC;
        end else if (d_req_s) begin
          state_d = D_ACC;
        end else begin
          state_d = IDLE;
        end
      end
      IF_ACC: state_d = IF_RSP;
      D_ACC:  state_d = D_RSP;
      IF_RSP: begin
        if (halt) begin
          state_d = HALTED;
        end else if (d_req_s) begin
          state_d = D_ACC;
        end else begin
          state_d = IDLE;
        end
      end
      D_RSP: begin
        if (halt) begin
          state_d = HALTED;
        end else if (if_req) begin
          state_d = IF_ACC;
        end else begin
          state_d = IDLE;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // Memory port decode: only ACC states (and the optional dump cycle) touch memory
  always_comb begin
    mem_addr       = {ADDR_W{1'b0}};
    mem_data_in    = {DATA_W{1'b0}};
    mem_enable     = 1'b0;
    mem_wr         = 1'b0;
    mem_createdump = 1'b0;
    case (state_q)
      IF_ACC: begin
        mem_addr   = if_addr;
        mem_enable = 1'b1;
      end
      D_ACC: begin
        mem_addr   = d_addr;
        mem_enable = 1'b1;
        mem_wr     = d_write_s;
        if (d_write_s) begin
          mem_data_in = d_wdata;
        end else begin
          mem_data_in = {DATA_W{1'b0}};
        end
      end
      HALTED: begin
`ifdef ARB_DUMP_ON_HALT_EN
        if (!dump_done_q) begin
          mem_enable     = 1'b1;
          mem_createdump = 1'b1;
        end else begin
          mem_enable     = 1'b0;
          mem_createdump = 1'b0;
        end
`else
        mem_enable = 1'b0;
`endif
      end
      default: begin
        mem_enable = 1'b0;
      end
    endcase
  end

  // State, fairness marker, sticky error and input history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      last_data_q    <= 1'b1;
      err_q          <= 1'b0;
      if_req_prev_q  <= 1'b0;
      if_rdy_prev_q  <= 1'b0;
      if_addr_prev_q <= {ADDR_W{1'b0}};
      d_req_prev_q   <= 1'b0;
      d_wr_prev_q    <= 1'b0;
      d_rdy_prev_q   <= 1'b0;
      d_addr_prev_q  <= {ADDR_W{1'b0}};
      d_wdata_prev_q <= {DATA_W{1'b0}};
    end else begin
      state_q        <= state_d;
      if (state_q == IF_ACC) begin
        last_data_q <= 1'b0;
      end else if (state_q == D_ACC) begin
        last_data_q <= 1'b1;
      end else begin
        last_data_q <= last_data_q;
      end
      err_q          <= err_q | err_set_s;
      if_req_prev_q  <= if_req;
      if_rdy_prev_q  <= if_ready;
      if_addr_prev_q <= if_addr;
      d_req_prev_q   <= d_req_s;
      d_wr_prev_q    <= d_wr;
      d_rdy_prev_q   <= d_ready;
      d_addr_prev_q  <= d_addr;
      d_wdata_prev_q <= d_wdata;
    end
  end

  // Read-data capture at the end of the access cycle; stores leave d_rdata alone
  always_ff @(posedge clk) begin
    if (rst) begin
      if_data_q <= {DATA_W{1'b0}};
      d_rdata_q <= {DATA_W{1'b0}};
    end else begin
      if (state_q == IF_ACC) begin
        if_data_q <= mem_data_out;
      end else begin
        if_data_q <= if_data_q;
      end
      if (state_q == D_ACC && !d_write_s) begin
        d_rdata_q <= mem_data_out;
      end else begin
        d_rdata_q <= d_rdata_q;
      end
    end
  end

endmodule
